router_fsm_ctrl: RTL and testbench

- Packet-sequencing controller for the 1x3 router.
- Decodes the header address, waits for the destination FIFO to drain, then steps the register/parity datapath through header, payload, full-stall and parity phases.
- Drives the datapath's phase strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) plus write-enable and busy.
- Sits between the input port, the three-FIFO synchroniser and the register block.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_wait_timer.sv | 29 ++
 rtl/router_fsm_ctrl.sv | 135 +++++++++++++
 tb/tb_router_fsm_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

    localparam int ADDR_W         = 2;
    localparam int NUM_PORTS      = 3;
    localparam int TIMEOUT_CYCLES = 30;

    localparam logic [1:0] INVALID_ADDR = 2'd3;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY abort; counts while waiting, clears otherwise.
module router_wait_timer #(
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_reg;

    // Saturates at the limit so a held wait cannot wrap back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!waiting) begin
            count_reg <= '0;
        end else if (count_reg != LIMIT) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = waiting && (count_reg == LIMIT);

endmodule

// File: rtl/router_fsm_ctrl.sv
// Router packet-sequencing FSM: header decode, drain wait, load/full/parity phases.
// Optional WAIT_TILL_EMPTY abort enabled by defining ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm_ctrl #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 30
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 write_enb_reg,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    output logic                 wait_timeout,
`endif
    output logic [ADDR_W-1:0]    dest_addr
);

    import router_pkg::*;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] dest_addr_reg;
    logic              header_ok;
    logic              timed_out;

    assign header_ok = pkt_valid && (data_in != INVALID_ADDR);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    logic timer_expired;

    router_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .waiting (state_reg == WAIT_TILL_EMPTY),
        .expired (timer_expired)
    );

    // An empty FIFO arriving on the limit cycle takes precedence over the abort.
    assign timed_out    = timer_expired && !fifo_empty[dest_addr_reg];
    assign wait_timeout = timed_out;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= DECODE_ADDRESS;
            dest_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE_ADDRESS && header_ok) begin
                dest_addr_reg <= data_in;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            DECODE_ADDRESS: begin
                if (header_ok) begin
                    state_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[dest_addr_reg]) begin
                    state_next = LOAD_FIRST_DATA;
                end else if (timed_out) begin
                    state_next = DECODE_ADDRESS;
                end
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_next = DECODE_ADDRESS;
        endcase
        // A read-side timeout on the selected FIFO abandons the packet in flight.
        if (state_reg != DECODE_ADDRESS && soft_reset[dest_addr_reg]) begin
            state_next = DECODE_ADDRESS;
        end
    end

    assign detect_add    = (state_reg == DECODE_ADDRESS);
    assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign ld_state      = (state_reg == LOAD_DATA);
    assign laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign full_state    = (state_reg == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY)
                        || (state_reg == LOAD_AFTER_FULL);
    assign busy          = (state_reg != DECODE_ADDRESS) && (state_reg != LOAD_DATA);
    assign dest_addr     = dest_addr_reg;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed self-checking bench for router_fsm_ctrl; state is observed via the output strobes.
module tb_router_fsm_ctrl;

    // Output signature: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0010;
    localparam logic [7:0] S_WT  = 8'b0000_0001;
    localparam logic [7:0] S_FF  = 8'b0000_1001;
    localparam logic [7:0] S_LAF = 8'b0001_0011;
    localparam logic [7:0] S_LP  = 8'b0000_0011;
    localparam logic [7:0] S_CPE = 8'b0000_0101;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;
    logic [1:0] dest_addr;
    logic [7:0] outs;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    logic       wait_timeout;
`endif

    int checks = 0;
    int errors = 0;

    router_fsm_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb_reg (write_enb_reg),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy),
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        .wait_timeout  (wait_timeout),
`endif
        .dest_addr     (dest_addr)
    );

    always #5 clock = ~clock;

    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        repeat (2) step();
        checks++;
        if (outs !== S_DA) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, S_DA); end
        checks++;
        if (dest_addr !== 2'd0) begin errors++; $display("FAIL reset_dest got %0d exp 0", dest_addr); end
        @(negedge clock); reset = 1'b0;
        step();
        checks++;
        if (outs !== S_DA) begin errors++; $display("FAIL idle_after_reset got %b exp %b", outs, S_DA); end
        $display("test_reset done");
    endtask

    task automatic test_normal_packet();
        logic [7:0] exp_seq [8] = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LP, S_CPE, S_DA};
        int we_cnt = 0;
        int ri_cnt = 0;
        pkt_valid = 1'b1; data_in = 2'd1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) pkt_valid = 1'b0;
            step();
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++; $display("FAIL normal_step%0d got %b exp %b", i, outs, exp_seq[i]);
            end
            if (write_enb_reg) we_cnt++;
            if (rst_int_reg) ri_cnt++;
        end
        checks++;
        if (dest_addr !== 2'd1) begin errors++; $display("FAIL normal_dest got %0d exp 1", dest_addr); end
        checks++;
        if (we_cnt != 5) begin errors++; $display("FAIL normal_we_cycles got %0d exp 5", we_cnt); end
        checks++;
        if (ri_cnt != 1) begin errors++; $display("FAIL normal_rst_int_cycles got %0d exp 1", ri_cnt); end
        $display("test_normal_packet done");
    endtask

    task automatic test_invalid_addr();
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs !== S_DA || dest_addr !== 2'd1) begin
                errors++; $display("FAIL invalid_addr%0d got %b/%0d exp %b/1", i, outs, dest_addr, S_DA);
            end
        end
        pkt_valid = 1'b0;
        $display("test_invalid_addr done");
    endtask

    task automatic test_wait_and_full();
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (outs !== S_WT) begin errors++; $display("FAIL wait%0d got %b exp %b", i, outs, S_WT); end
        end
        checks++;
        if (dest_addr !== 2'd2) begin errors++; $display("FAIL wait_dest got %0d exp 2", dest_addr); end
        fifo_empty = 3'b111;
        step();
        checks++;
        if (outs !== S_LFD) begin errors++; $display("FAIL wait_release got %b exp %b", outs, S_LFD); end
        step();
        checks++;
        if (outs !== S_LD) begin errors++; $display("FAIL wait_ld got %b exp %b", outs, S_LD); end
        // full and end-of-packet together: full must win
        fifo_full = 1'b1; pkt_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs !== S_FF) begin errors++; $display("FAIL full%0d got %b exp %b", i, outs, S_FF); end
        end
        fifo_full = 1'b0;
        step();
        checks++;
        if (outs !== S_LAF) begin errors++; $display("FAIL full_laf got %b exp %b", outs, S_LAF); end
        low_pkt_valid = 1'b1; parity_done = 1'b0;
        step();
        checks++;
        if (outs !== S_LP) begin errors++; $display("FAIL laf_to_lp got %b exp %b", outs, S_LP); end
        low_pkt_valid = 1'b0;
        step();
        step();
        checks++;
        if (outs !== S_DA) begin errors++; $display("FAIL wait_full_end got %b exp %b", outs, S_DA); end
        $display("test_wait_and_full done");
    endtask

    task automatic test_laf_branches();
        pkt_valid = 1'b1; data_in = 2'd0;
        step(); step();
        checks++;
        if (outs !== S_LD || dest_addr !== 2'd0) begin
            errors++; $display("FAIL laf_setup got %b/%0d exp %b/0", outs, dest_addr, S_LD);
        end
        fifo_full = 1'b1; step();
        fifo_full = 1'b0; step();
        step();  // LAF with neither flag -> back to LD
        checks++;
        if (outs !== S_LD) begin errors++; $display("FAIL laf_to_ld got %b exp %b", outs, S_LD); end
        pkt_valid = 1'b0; step();
        fifo_full = 1'b1; step();
        checks++;
        if (outs !== S_CPE) begin errors++; $display("FAIL lp_to_cpe got %b exp %b", outs, S_CPE); end
        step();
        checks++;
        if (outs !== S_FF) begin errors++; $display("FAIL cpe_to_full got %b exp %b", outs, S_FF); end
        fifo_full = 1'b0; step();
        parity_done = 1'b1; step();
        checks++;
        if (outs !== S_DA) begin errors++; $display("FAIL laf_parity_done got %b exp %b", outs, S_DA); end
        parity_done = 1'b0;
        $display("test_laf_branches done");
    endtask

    task automatic test_soft_reset();
        pkt_valid = 1'b1; data_in = 2'd0;
        step(); step();
        soft_reset = 3'b010;
        step();
        checks++;
        if (outs !== S_LD) begin errors++; $display("FAIL soft_reset_other got %b exp %b", outs, S_LD); end
        soft_reset = 3'b001;
        step();
        checks++;
        if (outs !== S_DA) begin errors++; $display("FAIL soft_reset_own got %b exp %b", outs, S_DA); end
        // still asserted while in DECODE_ADDRESS: ignored
        step();
        checks++;
        if (outs !== S_LFD) begin errors++; $display("FAIL soft_reset_in_decode got %b exp %b", outs, S_LFD); end
        soft_reset = 3'b000;
        $display("test_soft_reset done");
    endtask

    task automatic test_async_reset();
        pkt_valid = 1'b1; data_in = 2'd2;
        step();
        checks++;
        if (outs !== S_LD) begin errors++; $display("FAIL async_setup got %b exp %b", outs, S_LD); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outs !== S_DA || dest_addr !== 2'd0) begin
            errors++; $display("FAIL async_reset got %b/%0d exp %b/0", outs, dest_addr, S_DA);
        end
        pkt_valid = 1'b0;
        @(negedge clock); reset = 1'b0;
        $display("test_async_reset done");
    endtask

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        fifo_empty = 3'b011; pkt_valid = 1'b1; data_in = 2'd2;
        step();
        pkt_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (wait_timeout) pulses++;
            checks++;
            if (wait_timeout !== (i == 30) || outs !== S_WT) begin
                errors++; $display("FAIL timeout_cycle%0d got %b/%b exp %b/%b", i, wait_timeout, outs, (i == 30), S_WT);
            end
        end
        step();
        checks++;
        if (outs !== S_DA || wait_timeout !== 1'b0 || pulses != 1) begin
            errors++; $display("FAIL timeout_exit got %b/%b/%0d exp %b/0/1", outs, wait_timeout, pulses, S_DA);
        end
        fifo_empty = 3'b111;
        $display("test_timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_normal_packet();
        test_invalid_addr();
        test_wait_and_full();
        test_laf_branches();
        test_soft_reset();
        test_async_reset();
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
